// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-pin bundle for alu_arbiter.
// slave is the arbiter's view; master is the requesters, response consumer and ALU.
interface alu_arbiter_if #(
    parameter int unsigned W = 8
);
    logic [1:0]     REQ_VALID;
    logic [1:0]     REQ_READY;
    logic [2*W-1:0] REQ_OPA;
    logic [2*W-1:0] REQ_OPB;
    logic [7:0]     REQ_CMD;
    logic [1:0]     REQ_MODE;
    logic [1:0]     REQ_CIN;
    logic [3:0]     REQ_INP_VALID;

    logic           RSP_VALID;
    logic           RSP_READY;
    logic           RSP_ID;
    logic [2*W-1:0] RSP_RES;
    logic [5:0]     RSP_FLAGS;

    logic [W-1:0]   ALU_OPA;
    logic [W-1:0]   ALU_OPB;
    logic [3:0]     ALU_CMD;
    logic           ALU_MODE;
    logic           ALU_CIN;
    logic           ALU_CE;
    logic [1:0]     ALU_INP_VALID;
    logic [2*W-1:0] ALU_RES;
    logic           ALU_COUT;
    logic           ALU_OFLOW;
    logic           ALU_G;
    logic           ALU_E;
    logic           ALU_L;
    logic           ALU_ERR;

    modport slave (
        input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
        output REQ_READY,
        output RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS,
        input  RSP_READY,
        output ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
        input  ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR
    );

    modport master (
        output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
        input  REQ_READY,
        input  RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS,
        output RSP_READY,
        input  ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
        output ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU; one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default round-robin.
module alu_arbiter #(
    parameter int unsigned W       = 8,
    parameter int unsigned LAT     = 1,
    parameter int unsigned MUL_LAT = 2
) (
    input logic          CLK,
    input logic          RST,
    alu_arbiter_if.slave bus
);
    localparam int unsigned MaxLat = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           id_q, id_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [3:0]     cmd_q, cmd_d;
    logic           mode_q, mode_d;
    logic           cin_q, cin_d;
    logic           ce_q, ce_d;
    logic [1:0]     inp_valid_q, inp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [2*W-1:0] rsp_res_q, rsp_res_d;
    logic [5:0]     rsp_flags_q, rsp_flags_d;
    logic [1:0]     grant;
    logic           win;
    logic           is_mul;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           last_q, last_d;
`endif

    // Grant is gated by reset so REQ_READY reads 0 while RST is held low.
    always_comb begin
        grant = 2'b00;
        if (state_q == StIdle && RST) begin
            case (bus.REQ_VALID)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11:   grant = 2'b01;
`else
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign win    = grant[1];
    assign is_mul = mode_q && (cmd_q == 4'd9 || cmd_q == 4'd10);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        inp_valid_d = inp_valid_q;
        ce_d        = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                // The ALU pin registers double as the latch for the granted request.
                if (grant != 2'b00) begin
                    id_d        = win;
                    opa_d       = win ? bus.REQ_OPA[2*W-1:W] : bus.REQ_OPA[W-1:0];
                    opb_d       = win ? bus.REQ_OPB[2*W-1:W] : bus.REQ_OPB[W-1:0];
                    cmd_d       = win ? bus.REQ_CMD[7:4] : bus.REQ_CMD[3:0];
                    mode_d      = bus.REQ_MODE[win];
                    cin_d       = bus.REQ_CIN[win];
                    inp_valid_d = win ? bus.REQ_INP_VALID[3:2] : bus.REQ_INP_VALID[1:0];
                    ce_d        = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = is_mul ? CntW'(MUL_LAT) : CntW'(LAT);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end
                if (cnt_q <= CntW'(1)) begin
                    rsp_id_d    = id_q;
                    rsp_res_d   = bus.ALU_RES;
                    rsp_flags_d = {bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_G,
                                   bus.ALU_E, bus.ALU_L, bus.ALU_ERR};
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.RSP_READY) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d  = rsp_id_q;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            inp_valid_q <= '0;
            ce_q        <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            inp_valid_q <= inp_valid_d;
            ce_q        <= ce_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.REQ_READY     = grant;
    assign bus.RSP_VALID     = (state_q == StResp);
    assign bus.RSP_ID        = rsp_id_q;
    assign bus.RSP_RES       = rsp_res_q;
    assign bus.RSP_FLAGS     = rsp_flags_q;
    assign bus.ALU_OPA       = opa_q;
    assign bus.ALU_OPB       = opb_q;
    assign bus.ALU_CMD       = cmd_q;
    assign bus.ALU_MODE      = mode_q;
    assign bus.ALU_CIN       = cin_q;
    assign bus.ALU_CE        = ce_q;
    assign bus.ALU_INP_VALID = inp_valid_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus backpressure and mid-operation reset sequences.
module tb_alu_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_arbiter_if #(.W(8)) bus ();

    alu_arbiter #(.W(8), .LAT(1), .MUL_LAT(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Small ALU model: result registered on the CE edge and held until the next CE.
    logic [15:0] m_res = '0;
    logic [5:0]  m_flags = '0;
    logic [15:0] add_sum;
    assign add_sum = {8'h00, bus.ALU_OPA} + {8'h00, bus.ALU_OPB} + {15'd0, bus.ALU_CIN};
    always @(posedge CLK) begin
        if (bus.ALU_CE) begin
            m_res   <= '0;
            m_flags <= '0;
            if (bus.ALU_INP_VALID == 2'b00) begin
                m_flags <= 6'b000001;
            end else if (bus.ALU_MODE) begin
                if (bus.ALU_CMD == 4'd9 || bus.ALU_CMD == 4'd10) begin
                    m_res <= {8'h00, bus.ALU_OPA} * {8'h00, bus.ALU_OPB};
                end else if (bus.ALU_CMD == 4'd0) begin
                    m_res   <= add_sum;
                    m_flags <= {add_sum[8], 5'b00000};
                end
            end else begin
                m_res <= {8'h00, bus.ALU_OPA & bus.ALU_OPB};
            end
        end
    end
    assign bus.ALU_RES = m_res;
    assign {bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_G, bus.ALU_E, bus.ALU_L, bus.ALU_ERR} = m_flags;

    typedef struct packed {
        logic [1:0]  valid;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic [3:0]  cmd;
        logic        mode;
        logic [1:0]  iv;
        logic        id;
        logic [15:0] res;
        logic [5:0]  flags;
        logic [3:0]  lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #3;
    endtask

    task automatic drive(input vec_t v);
        bus.REQ_OPA       = {v.a1, v.a0};
        bus.REQ_OPB       = {v.b1, v.b0};
        bus.REQ_CMD       = {v.cmd, v.cmd};
        bus.REQ_MODE      = {v.mode, v.mode};
        bus.REQ_CIN       = 2'b00;
        bus.REQ_INP_VALID = {v.iv, v.iv};
        bus.REQ_VALID     = v.valid;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        drive(v);
        #1;
        n = 0;
        while (bus.REQ_READY == 2'b00 && n < 10) begin
            step();
            n++;
        end
        chk($sformatf("v%0d_grant", idx), 32'(bus.REQ_READY), v.id ? 32'h2 : 32'h1);
        step();
        bus.REQ_VALID = 2'b00;
        chk($sformatf("v%0d_ce_hi", idx), 32'(bus.ALU_CE), 32'h1);
        chk($sformatf("v%0d_alu_opa", idx), 32'(bus.ALU_OPA), 32'(v.id ? v.a1 : v.a0));
        step();
        chk($sformatf("v%0d_ce_lo", idx), 32'(bus.ALU_CE), 32'h0);
        n = 2;
        while (!bus.RSP_VALID && n < 12) begin
            step();
            n++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d_rsp_id", idx), 32'(bus.RSP_ID), 32'(v.id));
        chk($sformatf("v%0d_rsp_res", idx), 32'(bus.RSP_RES), 32'(v.res));
        chk($sformatf("v%0d_rsp_flags", idx), 32'(bus.RSP_FLAGS), 32'(v.flags));
        bus.RSP_READY = 1'b1;
        step();
        bus.RSP_READY = 1'b0;
        chk($sformatf("v%0d_rsp_drop", idx), 32'(bus.RSP_VALID), 32'h0);
    endtask

    initial begin
        vec_t v;
        int   n;
        logic [15:0] held_res;

        bus.REQ_VALID = 2'b00;
        bus.REQ_OPA = '0; bus.REQ_OPB = '0; bus.REQ_CMD = '0;
        bus.REQ_MODE = '0; bus.REQ_CIN = '0; bus.REQ_INP_VALID = '0;
        bus.RSP_READY = 1'b0;

        //                valid  a0     b0     a1     b1     cmd   m     iv     id    res       flags      lat
        vecs[0] = '{2'b11, 8'h01, 8'h02, 8'h10, 8'h02, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0003, 6'b000000, 4'd3};
`ifdef ALU_ARB_FIXED_PRIO_EN
        vecs[1] = '{2'b11, 8'h05, 8'h06, 8'h20, 8'h06, 4'd0, 1'b1, 2'b11, 1'b0, 16'h000B, 6'b000000, 4'd3};
`else
        vecs[1] = '{2'b11, 8'h05, 8'h06, 8'h20, 8'h06, 4'd0, 1'b1, 2'b11, 1'b1, 16'h0026, 6'b000000, 4'd3};
`endif
        vecs[2] = '{2'b11, 8'h10, 8'h01, 8'h30, 8'h01, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0011, 6'b000000, 4'd3};
`ifdef ALU_ARB_FIXED_PRIO_EN
        vecs[3] = '{2'b11, 8'h20, 8'h21, 8'h22, 8'h23, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0041, 6'b000000, 4'd3};
`else
        vecs[3] = '{2'b11, 8'h20, 8'h21, 8'h22, 8'h23, 4'd0, 1'b1, 2'b11, 1'b1, 16'h0045, 6'b000000, 4'd3};
`endif
        vecs[4] = '{2'b01, 8'h05, 8'h03, 8'h00, 8'h00, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0008, 6'b000000, 4'd3};
        vecs[5] = '{2'b10, 8'h00, 8'h00, 8'h03, 8'h04, 4'd9, 1'b1, 2'b11, 1'b1, 16'h000C, 6'b000000, 4'd4};
        vecs[6] = '{2'b01, 8'h05, 8'h03, 8'h00, 8'h00, 4'd0, 1'b1, 2'b00, 1'b0, 16'h0000, 6'b000001, 4'd3};
        vecs[7] = '{2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0100, 6'b100000, 4'd3};
        vecs[8] = '{2'b10, 8'h00, 8'h00, 8'hF0, 8'h3C, 4'd9, 1'b0, 2'b11, 1'b1, 16'h0030, 6'b000000, 4'd3};

        // Reset: all outputs low even with a request pending.
        #1 RST = 1'b0;
        bus.REQ_VALID = 2'b01;
        repeat (2) @(posedge CLK);
        #3;
        chk("reset_req_ready", 32'(bus.REQ_READY), 32'h0);
        chk("reset_rsp", {8'h0, bus.RSP_VALID, bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS}, 32'h0);
        chk("reset_alu", {7'h0, bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE, bus.ALU_CIN,
                          bus.ALU_CE, bus.ALU_INP_VALID}, 32'h0);
        bus.REQ_VALID = 2'b00;
        RST = 1'b1;
        step();
        chk("idle_no_req", 32'({bus.REQ_READY, bus.RSP_VALID, bus.ALU_CE}), 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: response from requester 0 held while requester 1 waits.
        v = '{2'b01, 8'h11, 8'h22, 8'h01, 8'h02, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0033, 6'b0, 4'd3};
        drive(v);
        #1;
        chk("bp_grant0", 32'(bus.REQ_READY), 32'h1);
        step();
        bus.REQ_VALID = 2'b10;
        n = 1;
        while (!bus.RSP_VALID && n < 12) begin
            step();
            n++;
        end
        chk("bp_latency", 32'(n), 32'h3);
        held_res = bus.RSP_RES;
        chk("bp_res", 32'(held_res), 32'h0033);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_hold%0d_valid", c), 32'(bus.RSP_VALID), 32'h1);
            chk($sformatf("bp_hold%0d_stable", c), {15'h0, bus.RSP_ID, bus.RSP_RES},
                {16'h0, held_res});
            chk($sformatf("bp_hold%0d_ready", c), 32'(bus.REQ_READY), 32'h0);
        end
        bus.RSP_READY = 1'b1;
        #1;
        chk("bp_consume_cycle_ready", 32'(bus.REQ_READY), 32'h0);
        @(posedge CLK);
        #1;
        bus.RSP_READY = 1'b0;
        #2;
        chk("bp_next_grant", 32'(bus.REQ_READY), 32'h2);
        step();
        bus.REQ_VALID = 2'b00;
        n = 1;
        while (!bus.RSP_VALID && n < 12) begin
            step();
            n++;
        end
        chk("bp_r1_resp", {15'h0, bus.RSP_ID, bus.RSP_RES}, 32'h0001_0003);
        bus.RSP_READY = 1'b1;
        step();
        bus.RSP_READY = 1'b0;

        // Mid-operation reset: leave last=0, abort in WAIT, then a tie goes to requester 0.
        v = '{2'b01, 8'h07, 8'h01, 8'h00, 8'h00, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0008, 6'b0, 4'd3};
        run_vec(v, 90);
        v = '{2'b01, 8'h12, 8'h34, 8'h12, 8'h34, 4'd0, 1'b1, 2'b11, 1'b0, 16'h0046, 6'b0, 4'd3};
        drive(v);
        #1;
        chk("rst_pre_grant", 32'(bus.REQ_READY), 32'h1);
        step();
        bus.REQ_VALID = 2'b11;
        step();
        RST = 1'b0;
        #1;
        chk("rst_async_rsp", {8'h0, bus.RSP_VALID, bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS}, 32'h0);
        chk("rst_async_alu", {7'h0, bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
                              bus.ALU_CIN, bus.ALU_CE, bus.ALU_INP_VALID}, 32'h0);
        chk("rst_async_ready", 32'(bus.REQ_READY), 32'h0);
        step();
        step();
        RST = 1'b1;
        #1;
        chk("rst_tie_grant", 32'(bus.REQ_READY), 32'h1);
        step();
        bus.REQ_VALID = 2'b00;
        n = 1;
        while (!bus.RSP_VALID && n < 12) begin
            step();
            n++;
        end
        chk("rst_after_latency", 32'(n), 32'h3);
        chk("rst_after_resp", {15'h0, bus.RSP_ID, bus.RSP_RES}, 32'h0000_0046);
        bus.RSP_READY = 1'b1;
        step();
        bus.RSP_READY = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
